// File: rtl/calc_pkg.sv
// calc_pkg: types and constants shared by the matrix calculator datapath
// stages (sign-magnitude multiplier and adder).
//   mul_state_t : multiplier control states IDLE/LOAD/MUL/FIN
//   CALC_WIDTH  : total sign-magnitude word width (MSB = sign)
//   CALC_MAG    : magnitude bits per word
package calc_pkg;

    localparam int CALC_WIDTH = 16;
    localparam int CALC_MAG   = CALC_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MUL  = 2'd2,
        FIN  = 2'd3
    } mul_state_t;

endpackage

// File: rtl/sm_mul_datapath.sv
// sm_mul_datapath: shift-add magnitude datapath of the sign-magnitude multiplier.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   load          : capture operand magnitudes, clear accumulator and counter
//   step          : perform one shift-add iteration
//   mcand_in      : multiplicand magnitude (MAG bits)
//   mplr_in       : multiplier magnitude (MAG bits)
//   acc           : 2*MAG-bit product accumulator
//   done          : all MAG iterations have been performed
module sm_mul_datapath
    import calc_pkg::*;
#(
    parameter int MAG = CALC_MAG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [MAG-1:0]     mcand_in,
    input  logic [MAG-1:0]     mplr_in,
    output logic [2*MAG-1:0]   acc,
    output logic               done
);

    localparam int CNT_W = $clog2(MAG + 1);

    logic [2*MAG-1:0] acc_r;
    logic [MAG-1:0]   mcand_r;
    logic [MAG-1:0]   mplr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2*MAG-1:0] addend_s;

    // Multiplicand aligned to the weight of the current multiplier bit.
    always_comb begin
        addend_s = {{MAG{1'b0}}, mcand_r} << cnt_r;
    end

    // Operand capture and one shift-add iteration per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= {(2*MAG){1'b0}};
            mcand_r <= {MAG{1'b0}};
            mplr_r  <= {MAG{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (load) begin
            acc_r   <= {(2*MAG){1'b0}};
            mcand_r <= mcand_in;
            mplr_r  <= mplr_in;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (step) begin
            if (mplr_r[0]) begin
                acc_r <= acc_r + addend_s;
            end else begin
                acc_r <= acc_r;
            end
            mplr_r <= mplr_r >> 1;
            cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_r   <= acc_r;
            mcand_r <= mcand_r;
            mplr_r  <= mplr_r;
            cnt_r   <= cnt_r;
        end
    end

    assign acc  = acc_r;
    assign done = (cnt_r == CNT_W'(MAG));

endmodule

// File: rtl/sm_multiplier.sv
// sm_multiplier: sequential sign-magnitude multiplier (level start/finish
// handshake), feeding the sign-magnitude adder of the matrix calculator.
// Ports:
//   clk     : clock, rising edge
//   RST     : asynchronous active-high reset
//   start   : level request, held until finish is seen
//   INn1    : multiplicand, sign-magnitude
//   INn2    : multiplier, sign-magnitude
//   out     : registered product, sign-magnitude
//   finish  : result valid (high while in FIN)
//   ovf     : product magnitude did not fit in MAG bits, valid with finish
// Build option: define SM_MUL_SAT_EN to saturate the magnitude to all ones on
// overflow; otherwise the magnitude is truncated to its low MAG bits.
module sm_multiplier
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] INn1,
    input  logic [WIDTH-1:0] INn2,
    output logic [WIDTH-1:0] out,
    output logic             finish,
    output logic             ovf
);

    localparam int MAG = WIDTH - 1;

    mul_state_t       state_r;
    mul_state_t       next_s;
    logic             sgn_r;
    logic [WIDTH-1:0] out_r;
    logic             finish_r;
    logic             ovf_r;
    logic [2*MAG-1:0] acc_s;
    logic             done_s;
    logic             load_s;
    logic             step_s;
    logic             ovf_s;
    logic [MAG-1:0]   mag_s;
    logic             sign_s;

    sm_mul_datapath #(.MAG(MAG)) u_datapath (
        .clk      (clk),
        .rst      (RST),
        .load     (load_s),
        .step     (step_s),
        .mcand_in (INn1[MAG-1:0]),
        .mplr_in  (INn2[MAG-1:0]),
        .acc      (acc_s),
        .done     (done_s)
    );

    // Next-state logic and datapath controls.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_s = LOAD;
                else       next_s = IDLE;
            end
            LOAD: next_s = MUL;
            MUL: begin
                if (done_s) next_s = FIN;
                else        next_s = MUL;
            end
            FIN: begin
                if (!start) next_s = IDLE;
                else        next_s = FIN;
            end
            default: next_s = IDLE;
        endcase
        load_s = (state_r == LOAD);
        step_s = (state_r == MUL) && !done_s;
    end

    // Result formatting: overflow flag, magnitude rule, no negative zero.
    always_comb begin
        ovf_s = |acc_s[2*MAG-1:MAG];
`ifdef SM_MUL_SAT_EN
        if (ovf_s) mag_s = {MAG{1'b1}};
        else       mag_s = acc_s[MAG-1:0];
`else
        mag_s = acc_s[MAG-1:0];
`endif
        sign_s = sgn_r & (mag_s != {MAG{1'b0}});
    end

    // State register, product sign and registered outputs.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_r  <= IDLE;
            sgn_r    <= 1'b0;
            out_r    <= {WIDTH{1'b0}};
            ovf_r    <= 1'b0;
            finish_r <= 1'b0;
        end else begin
            state_r  <= next_s;
            finish_r <= (next_s == FIN);
            if (state_r == LOAD) begin
                sgn_r <= INn1[MAG] ^ INn2[MAG];
            end else begin
                sgn_r <= sgn_r;
            end
            // out/ovf only change on the MUL->FIN edge and otherwise hold.
            if ((state_r == MUL) && done_s) begin
                out_r <= {sign_s, mag_s};
                ovf_r <= ovf_s;
            end else begin
                out_r <= out_r;
                ovf_r <= ovf_r;
            end
        end
    end

    assign out    = out_r;
    assign finish = finish_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_sm_multiplier.sv
// tb_sm_multiplier: self-checking bench for sm_multiplier. Directed vectors from
// a table, randomized operands checked against an arithmetic reference model,
// and hand-written sequences for early start drop and mid-operation reset.
module tb_sm_multiplier;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] INn1;
    logic [15:0] INn2;
    logic [15:0] out;
    logic        finish;
    logic        ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sm_multiplier dut (
        .clk    (clk),
        .RST    (RST),
        .start  (start),
        .INn1   (INn1),
        .INn2   (INn2),
        .out    (out),
        .finish (finish),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_out;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: integer product of the magnitudes, then sign/overflow rules.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        longint unsigned p;
        logic            o;
        logic [14:0]     m;
        logic            s;
        p = longint'(a[14:0]) * longint'(b[14:0]);
        o = (p > 64'd32767);
`ifdef SM_MUL_SAT_EN
        m = o ? 15'h7FFF : 15'(p % 64'd32768);
`else
        m = 15'(p % 64'd32768);
`endif
        s = (a[15] ^ b[15]) && (m != 15'd0);
        return {o, s, m};
    endfunction

    // One operation. drop_at >= 0 releases start right after that edge index
    // (edge 0 = first edge sampling start). Inputs are scrambled after capture.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int drop_at,
                          output logic [15:0] o, output logic v, output int lat);
        @(negedge clk);
        INn1  = a;
        INn2  = b;
        start = 1'b1;
        lat   = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (finish) begin
                lat = i;
                break;
            end
            if (i >= 1) begin
                INn1 = 16'($urandom);
                INn2 = 16'($urandom);
            end
            if (i == drop_at) start = 1'b0;
        end
        o = out;
        v = ovf;
        if (lat < 0) begin
            check("timeout_finish", 32'd0, 32'd1);
            start = 1'b0;
        end else if (drop_at >= 0) begin
            @(posedge clk);
            #1;
            check("pulse_finish_low", {31'd0, finish}, 32'd0);
        end else begin
            for (int h = 0; h < 2; h++) begin
                @(posedge clk);
                #1;
                check("hold_finish", {31'd0, finish}, 32'd1);
                check("hold_out", {16'd0, out}, {16'd0, o});
            end
            start = 1'b0;
            @(posedge clk);
            #1;
            check("idle_finish_low", {31'd0, finish}, 32'd0);
            check("idle_out_kept", {16'd0, out}, {16'd0, o});
        end
    endtask

    initial begin
        vec_t        vecs[5];
        logic [15:0] o;
        logic        v;
        int          lat;
        logic [16:0] m;
        logic [15:0] a;
        logic [15:0] b;

        vecs[0] = '{16'h0003, 16'h0005, 16'h000F, 1'b0};
        vecs[1] = '{16'h8003, 16'h0005, 16'h800F, 1'b0};
        vecs[2] = '{16'h8007, 16'h8009, 16'h003F, 1'b0};
        vecs[3] = '{16'h8000, 16'h0005, 16'h0000, 1'b0};
`ifdef SM_MUL_SAT_EN
        vecs[4] = '{16'h8100, 16'h0100, 16'hFFFF, 1'b1};
`else
        vecs[4] = '{16'h8100, 16'h0100, 16'h0000, 1'b1};
`endif

        RST   = 1'b1;
        start = 1'b0;
        INn1  = 16'd0;
        INn2  = 16'd0;
        #2;
        check("reset_out", {16'd0, out}, 32'd0);
        check("reset_finish", {31'd0, finish}, 32'd0);
        check("reset_ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        RST = 1'b0;

        for (int k = 0; k < 5; k++) begin
            run_op(vecs[k].a, vecs[k].b, -1, o, v, lat);
            check("vec_out", {16'd0, o}, {16'd0, vecs[k].exp_out});
            check("vec_ovf", {31'd0, v}, {31'd0, vecs[k].exp_ovf});
            check("vec_latency", 32'(lat), 32'd17);
        end

        // start released early: operation completes, one-cycle finish pulse.
        run_op(16'h0003, 16'h0005, 5, o, v, lat);
        check("drop_out", {16'd0, o}, 32'h000F);
        check("drop_latency", 32'(lat), 32'd17);

        for (int r = 0; r < 24; r++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (r % 2 == 0) b[14:0] = 15'($urandom_range(0, 255));
            m = model(a, b);
            run_op(a, b, (r % 3 == 0) ? int'($urandom_range(2, 15)) : -1, o, v, lat);
            check("rand_out", {16'd0, o}, {16'd0, m[15:0]});
            check("rand_ovf", {31'd0, v}, {31'd0, m[16]});
            check("rand_latency", 32'(lat), 32'd17);
        end

        // Reset in the middle of an operation aborts at once.
        run_op(16'h0003, 16'h0005, -1, o, v, lat);
        @(negedge clk);
        INn1  = 16'h0007;
        INn2  = 16'h0009;
        start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        RST   = 1'b1;
        start = 1'b0;
        #1;
        check("rst_mid_out", {16'd0, out}, 32'd0);
        check("rst_mid_finish", {31'd0, finish}, 32'd0);
        check("rst_mid_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        RST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_idle_finish", {31'd0, finish}, 32'd0);
        run_op(16'h0002, 16'h0002, -1, o, v, lat);
        check("after_rst_out", {16'd0, o}, 32'h0004);
        check("after_rst_latency", 32'(lat), 32'd17);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
